// File: rtl/tlb_inst_ctrl_pkg.sv
// Shared types and constants for the EX-stage TLB instruction sequencer.
package tlb_ctrl_pkg;

  localparam int unsigned TLBNUM        = 32;
  localparam int unsigned IDXW          = $clog2(TLBNUM);
  localparam int unsigned RET_TIMEOUT   = 4;
  localparam int unsigned TMOW          = $clog2(RET_TIMEOUT + 1);
  localparam int unsigned INVTLB_OP_MAX = 6;

  // TLBIDX CSR field positions
  localparam int unsigned TLBIDX_NE       = 31;
  localparam int unsigned TLBIDX_PS_HI    = 29;
  localparam int unsigned TLBIDX_PS_LO    = 24;
  localparam int unsigned TLBIDX_INDEX_HI = 4;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } tlb_ctrl_state_t;

  typedef struct packed {
    logic srch;
    logic rd;
    logic wr;
    logic fill;
    logic inv;
  } tlb_en_t;

  typedef struct packed {
    logic idx;
    logic ehi;
    logic elo0;
    logic elo1;
    logic asid;
  } tlb_we_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] ehi;
    logic [31:0] elo0;
    logic [31:0] elo1;
    logic [9:0]  asid;
  } tlb_wb_t;

  function automatic tlb_en_t op_to_en(input tlb_op_t op);
    tlb_en_t en;
    en = '0;
    case (op)
      OP_SRCH: en.srch = 1'b1;
      OP_RD:   en.rd   = 1'b1;
      OP_WR:   en.wr   = 1'b1;
      OP_FILL: en.fill = 1'b1;
      OP_INV:  en.inv  = 1'b1;
      default: en = '0;
    endcase
    return en;
  endfunction

  // Unknown opcodes and INVTLB ops beyond the architected range complete with an exception
  function automatic logic op_illegal(input tlb_op_t op, input logic [4:0] inv_op);
    logic ill;
    case (op)
      OP_SRCH, OP_RD, OP_WR, OP_FILL: ill = 1'b0;
      OP_INV:  ill = (inv_op > 5'(INVTLB_OP_MAX));
      default: ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/tlb_inst_ctrl_rand_idx.sv
// Free-running TLBFILL index counter; its value is captured when a request is accepted.
module tlb_rand_idx
  import tlb_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_accept,
  output logic [IDXW-1:0] o_rand_index
);

  logic [IDXW-1:0] r_cnt;
  logic [IDXW-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= (r_cnt == IDXW'(TLBNUM - 1)) ? '0 : r_cnt + IDXW'(1);
      if (i_accept) begin
        r_idx <= r_cnt;
      end
    end
  end

  assign o_rand_index = r_idx;

endmodule

// File: rtl/tlb_inst_ctrl.sv
// EX-stage sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: issues TLB commands,
// collects search/read results and produces the CSR write-back and completion pulse.
module tlb_inst_ctrl
  import tlb_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  tlb_op_t         req_op,
  input  logic [4:0]      req_inv_op,
  input  logic [9:0]      req_inv_asid,
  input  logic [18:0]     req_inv_vpn,
  input  logic            flush,
  input  logic [31:0]     csr_tlbidx_in,
  output logic            tlbsrch_en,
  output logic            tlbrd_en,
  output logic            tlbwr_en,
  output logic            tlbfill_en,
  output logic            invtlb_en,
  output logic [4:0]      invtlb_op,
  output logic [9:0]      invtlb_asid,
  output logic [18:0]     invtlb_vpn,
  output logic [IDXW-1:0] rand_index,
  input  logic            tlbsrch_ret,
  input  logic            tlbrd_ret,
  input  logic            search_tlb_found,
  input  logic [IDXW-1:0] search_tlb_index,
  input  logic            tlbrd_valid,
  input  logic [31:0]     tlbehi_out,
  input  logic [31:0]     tlbelo0_out,
  input  logic [31:0]     tlbelo1_out,
  input  logic [31:0]     tlbidx_out,
  input  logic [9:0]      asid_out,
  output logic            csr_tlbidx_we,
  output logic            csr_tlbehi_we,
  output logic            csr_tlbelo0_we,
  output logic            csr_tlbelo1_we,
  output logic            csr_asid_we,
  output logic [31:0]     csr_tlbidx_wdata,
  output logic [31:0]     csr_tlbehi_wdata,
  output logic [31:0]     csr_tlbelo0_wdata,
  output logic [31:0]     csr_tlbelo1_wdata,
  output logic [9:0]      csr_asid_wdata,
  output logic            done_valid,
  output logic            done_excp
);

  tlb_ctrl_state_t r_state, w_state_nxt;
  tlb_op_t         r_op, w_op_nxt;
  logic [4:0]      r_inv_op, w_inv_op_nxt;
  logic [9:0]      r_inv_asid, w_inv_asid_nxt;
  logic [18:0]     r_inv_vpn, w_inv_vpn_nxt;
  tlb_en_t         r_en, w_en_nxt;
  logic            r_excp, w_excp_nxt;
  logic            r_drop, w_drop_nxt;
  logic [TMOW-1:0] r_tmo_cnt, w_tmo_nxt;
  logic            r_done_valid, w_done_nxt;
  logic            r_done_excp, w_done_excp_nxt;
  tlb_we_t         r_we, w_we_nxt;
  tlb_wb_t         r_wb, w_wb_nxt;
  logic            r_req_ready, w_req_ready_nxt;
  logic            w_accept;
  logic            w_ret;
  logic            w_unused;

  assign w_ret    = (r_op == OP_SRCH) ? tlbsrch_ret : tlbrd_ret;
  assign w_unused = ^{csr_tlbidx_in[TLBIDX_NE], tlbidx_out[31:30], tlbidx_out[23:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_SRCH;
      r_inv_op     <= '0;
      r_inv_asid   <= '0;
      r_inv_vpn    <= '0;
      r_en         <= '0;
      r_excp       <= 1'b0;
      r_drop       <= 1'b0;
      r_tmo_cnt    <= '0;
      r_done_valid <= 1'b0;
      r_done_excp  <= 1'b0;
      r_we         <= '0;
      r_wb         <= '0;
      r_req_ready  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_inv_op     <= w_inv_op_nxt;
      r_inv_asid   <= w_inv_asid_nxt;
      r_inv_vpn    <= w_inv_vpn_nxt;
      r_en         <= w_en_nxt;
      r_excp       <= w_excp_nxt;
      r_drop       <= w_drop_nxt;
      r_tmo_cnt    <= w_tmo_nxt;
      r_done_valid <= w_done_nxt;
      r_done_excp  <= w_done_excp_nxt;
      r_we         <= w_we_nxt;
      r_wb         <= w_wb_nxt;
      r_req_ready  <= w_req_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_inv_op_nxt    = r_inv_op;
    w_inv_asid_nxt  = r_inv_asid;
    w_inv_vpn_nxt   = r_inv_vpn;
    w_en_nxt        = '0;
    w_excp_nxt      = r_excp;
    w_drop_nxt      = r_drop;
    w_tmo_nxt       = r_tmo_cnt;
    w_done_nxt      = 1'b0;
    w_done_excp_nxt = 1'b0;
    w_we_nxt        = '0;
    w_wb_nxt        = r_wb;
    w_accept        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_req_ready && req_valid && !flush) begin
          w_accept       = 1'b1;
          w_op_nxt       = req_op;
          w_inv_op_nxt   = req_inv_op;
          w_inv_asid_nxt = req_inv_asid;
          w_inv_vpn_nxt  = req_inv_vpn;
          w_excp_nxt     = op_illegal(req_op, req_inv_op);
          w_en_nxt       = op_illegal(req_op, req_inv_op) ? '0 : op_to_en(req_op);
          w_drop_nxt     = 1'b0;
          w_tmo_nxt      = '0;
          w_state_nxt    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_excp) begin
          w_done_nxt      = 1'b1;
          w_done_excp_nxt = 1'b1;
          w_state_nxt     = ST_DONE;
        end else if (r_op == OP_SRCH || r_op == OP_RD) begin
          w_state_nxt = ST_WAIT;
        end else begin
          // WR/FILL/INV commit in the TLB on this edge; nothing to wait for
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end

      ST_WAIT: begin
        w_drop_nxt = r_drop | flush;
        if (w_ret) begin
          w_done_nxt  = 1'b1;
          w_tmo_nxt   = '0;
          w_state_nxt = ST_DONE;
          if (!(r_drop || flush)) begin
            if (r_op == OP_SRCH) begin
              w_we_nxt.idx = 1'b1;
              w_wb_nxt.idx = search_tlb_found
                ? {1'b0, csr_tlbidx_in[TLBIDX_NE-1:TLBIDX_INDEX_HI+1], search_tlb_index}
                : {1'b1, csr_tlbidx_in[TLBIDX_NE-1:0]};
            end else begin
              w_we_nxt     = '1;
              w_wb_nxt.idx = {~tlbrd_valid, csr_tlbidx_in[TLBIDX_NE-1],
                              tlbrd_valid ? tlbidx_out[TLBIDX_PS_HI:TLBIDX_PS_LO] : 6'd0,
                              csr_tlbidx_in[TLBIDX_PS_LO-1:0]};
              w_wb_nxt.ehi  = tlbrd_valid ? tlbehi_out  : '0;
              w_wb_nxt.elo0 = tlbrd_valid ? tlbelo0_out : '0;
              w_wb_nxt.elo1 = tlbrd_valid ? tlbelo1_out : '0;
              w_wb_nxt.asid = tlbrd_valid ? asid_out    : '0;
            end
          end
        end else if (r_tmo_cnt == TMOW'(RET_TIMEOUT - 1)) begin
          w_excp_nxt      = 1'b1;
          w_done_nxt      = 1'b1;
          w_done_excp_nxt = 1'b1;
          w_tmo_nxt       = '0;
          w_state_nxt     = ST_DONE;
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMOW'(1);
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  tlb_rand_idx u_rand_idx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_accept     (w_accept),
    .o_rand_index (rand_index)
  );

  // Command enables and CSR write enables are withdrawn by a same-cycle flush
  assign tlbsrch_en = r_en.srch & ~flush;
  assign tlbrd_en   = r_en.rd   & ~flush;
  assign tlbwr_en   = r_en.wr   & ~flush;
  assign tlbfill_en = r_en.fill & ~flush;
  assign invtlb_en  = r_en.inv  & ~flush;

  assign invtlb_op   = r_inv_op;
  assign invtlb_asid = r_inv_asid;
  assign invtlb_vpn  = r_inv_vpn;

  assign csr_tlbidx_we  = r_we.idx  & ~flush;
  assign csr_tlbehi_we  = r_we.ehi  & ~flush;
  assign csr_tlbelo0_we = r_we.elo0 & ~flush;
  assign csr_tlbelo1_we = r_we.elo1 & ~flush;
  assign csr_asid_we    = r_we.asid & ~flush;

  assign csr_tlbidx_wdata  = r_wb.idx;
  assign csr_tlbehi_wdata  = r_wb.ehi;
  assign csr_tlbelo0_wdata = r_wb.elo0;
  assign csr_tlbelo1_wdata = r_wb.elo1;
  assign csr_asid_wdata    = r_wb.asid;

  assign req_ready  = r_req_ready;
  assign done_valid = r_done_valid;
  assign done_excp  = r_done_excp;

endmodule

// File: tb/tb_tlb_inst_ctrl.sv
// Scoreboard bench for tlb_inst_ctrl: driver queues expected enables/completions, monitor checks them.
`timescale 1ns/1ps
module tb_tlb_inst_ctrl;
  import tlb_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    logic        excp;
    logic [4:0]  we;
    logic [31:0] idx;
    logic [31:0] ehi;
    logic [31:0] elo0;
    logic [31:0] elo1;
    logic [9:0]  asid;
  } done_exp_t;

  typedef struct {
    int          cyc;
    logic [4:0]  en;
    logic [4:0]  rnd;
    logic [4:0]  iop;
    logic [9:0]  asid;
    logic [18:0] vpn;
  } en_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  tlb_op_t req_op = OP_SRCH;
  logic [4:0]  req_inv_op = '0;
  logic [9:0]  req_inv_asid = '0;
  logic [18:0] req_inv_vpn = '0;
  logic flush = 1'b0;
  logic [31:0] csr_tlbidx_in = '0;
  logic tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en;
  logic [4:0]  invtlb_op;
  logic [9:0]  invtlb_asid;
  logic [18:0] invtlb_vpn;
  logic [IDXW-1:0] rand_index;
  logic tlbsrch_ret = 1'b0, tlbrd_ret = 1'b0;
  logic search_tlb_found = 1'b0;
  logic [IDXW-1:0] search_tlb_index = '0;
  logic tlbrd_valid = 1'b0;
  logic [31:0] tlbehi_out = '0, tlbelo0_out = '0, tlbelo1_out = '0, tlbidx_out = '0;
  logic [9:0]  asid_out = '0;
  logic csr_tlbidx_we, csr_tlbehi_we, csr_tlbelo0_we, csr_tlbelo1_we, csr_asid_we;
  logic [31:0] csr_tlbidx_wdata, csr_tlbehi_wdata, csr_tlbelo0_wdata, csr_tlbelo1_wdata;
  logic [9:0]  csr_asid_wdata;
  logic done_valid, done_excp;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [4:0] m_cnt;
  bit resp_mute = 1'b0;
  done_exp_t done_q[$];
  en_exp_t   en_q[$];

  tlb_inst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid),
    .req_inv_vpn(req_inv_vpn), .flush(flush), .csr_tlbidx_in(csr_tlbidx_in),
    .tlbsrch_en(tlbsrch_en), .tlbrd_en(tlbrd_en), .tlbwr_en(tlbwr_en),
    .tlbfill_en(tlbfill_en), .invtlb_en(invtlb_en), .invtlb_op(invtlb_op),
    .invtlb_asid(invtlb_asid), .invtlb_vpn(invtlb_vpn), .rand_index(rand_index),
    .tlbsrch_ret(tlbsrch_ret), .tlbrd_ret(tlbrd_ret),
    .search_tlb_found(search_tlb_found), .search_tlb_index(search_tlb_index),
    .tlbrd_valid(tlbrd_valid), .tlbehi_out(tlbehi_out), .tlbelo0_out(tlbelo0_out),
    .tlbelo1_out(tlbelo1_out), .tlbidx_out(tlbidx_out), .asid_out(asid_out),
    .csr_tlbidx_we(csr_tlbidx_we), .csr_tlbehi_we(csr_tlbehi_we),
    .csr_tlbelo0_we(csr_tlbelo0_we), .csr_tlbelo1_we(csr_tlbelo1_we),
    .csr_asid_we(csr_asid_we), .csr_tlbidx_wdata(csr_tlbidx_wdata),
    .csr_tlbehi_wdata(csr_tlbehi_wdata), .csr_tlbelo0_wdata(csr_tlbelo0_wdata),
    .csr_tlbelo1_wdata(csr_tlbelo1_wdata), .csr_asid_wdata(csr_asid_wdata),
    .done_valid(done_valid), .done_excp(done_excp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the free-running fill counter
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= '0;
    else        m_cnt <= m_cnt + 5'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic done_exp_t mk_done(input logic excp, input logic [4:0] we,
                                        input logic [31:0] idx, input logic [31:0] ehi,
                                        input logic [31:0] elo0, input logic [31:0] elo1,
                                        input logic [9:0] asid);
    done_exp_t d;
    d.cyc = 0; d.excp = excp; d.we = we; d.idx = idx;
    d.ehi = ehi; d.elo0 = elo0; d.elo1 = elo1; d.asid = asid;
    return d;
  endfunction

  function automatic logic [4:0] op_vec(input tlb_op_t op);
    case (op)
      OP_SRCH: return 5'b10000;
      OP_RD:   return 5'b01000;
      OP_WR:   return 5'b00100;
      OP_FILL: return 5'b00010;
      default: return 5'b00001;
    endcase
  endfunction

  // Accept one request; optionally wait for a given fill-counter value first
  task automatic issue(input tlb_op_t op, input logic [4:0] iop, input logic [9:0] asid,
                       input logic [18:0] vpn, input int want_cnt, input bit exp_en,
                       input bit exp_done, input int dly, input done_exp_t d);
    int k;
    logic [4:0] rnd;
    en_exp_t e;
    done_exp_t dd;
    k = 0;
    @(negedge clk);
    while (!(req_ready === 1'b1 && (want_cnt < 0 || int'(m_cnt) == want_cnt)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("accept_wait_timeout", 32'(k), 32'd0);
    req_valid = 1'b1; req_op = op; req_inv_op = iop; req_inv_asid = asid; req_inv_vpn = vpn;
    rnd = m_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (exp_en) begin
      e.cyc = cyc; e.en = op_vec(op); e.rnd = rnd; e.iop = iop; e.asid = asid; e.vpn = vpn;
      en_q.push_back(e);
    end
    if (exp_done) begin
      dd = d;
      dd.cyc = cyc + dly;
      done_q.push_back(dd);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (!(done_q.size() == 0 && req_ready === 1'b1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("drain_timeout", 32'(done_q.size()), 32'd0);
  endtask

  // TLB responder: registered ret one cycle after the enable
  initial begin
    bit is_srch;
    forever begin
      @(negedge clk);
      if (!resp_mute && rst_n && (tlbsrch_en || tlbrd_en)) begin
        is_srch = tlbsrch_en;
        @(posedge clk); #1;
        if (is_srch) tlbsrch_ret = 1'b1; else tlbrd_ret = 1'b1;
        @(posedge clk); #1;
        tlbsrch_ret = 1'b0; tlbrd_ret = 1'b0;
      end
    end
  end

  // Monitor: compares every enable and completion against the queued expectations
  initial begin
    logic [4:0] en_v, we_v;
    en_exp_t e;
    done_exp_t d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        en_v = {tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en};
        if (en_v != 5'b0) begin
          if (en_q.size() == 0) chk("unexpected_enable", 32'(en_v), 32'd0);
          else begin
            e = en_q.pop_front();
            chk("enable_vec", 32'(en_v), 32'(e.en));
            chk("enable_cycle", 32'(cyc), 32'(e.cyc));
            if (e.en[1]) chk("fill_rand_index", 32'(rand_index), 32'(e.rnd));
            if (e.en[0]) chk("invtlb_operands", {3'b0, invtlb_op, invtlb_asid, invtlb_vpn[13:0]},
                             {3'b0, e.iop, e.asid, e.vpn[13:0]});
            if (e.en[0]) chk("invtlb_vpn_hi", 32'(invtlb_vpn[18:14]), 32'(e.vpn[18:14]));
          end
        end
        if (done_valid) begin
          we_v = {csr_tlbidx_we, csr_tlbehi_we, csr_tlbelo0_we, csr_tlbelo1_we, csr_asid_we};
          if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            d = done_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(d.cyc));
            chk("done_excp", 32'(done_excp), 32'(d.excp));
            chk("csr_we_vec", 32'(we_v), 32'(d.we));
            if (d.we[4]) chk("tlbidx_wdata", csr_tlbidx_wdata, d.idx);
            if (d.we[3]) chk("tlbehi_wdata", csr_tlbehi_wdata, d.ehi);
            if (d.we[2]) chk("tlbelo0_wdata", csr_tlbelo0_wdata, d.elo0);
            if (d.we[1]) chk("tlbelo1_wdata", csr_tlbelo1_wdata, d.elo1);
            if (d.we[0]) chk("asid_wdata", 32'(csr_asid_wdata), 32'(d.asid));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_done", {30'd0, done_valid, done_excp}, 32'd0);
    chk("reset_enables", 32'({tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en}), 32'd0);
    chk("reset_csr_we", 32'({csr_tlbidx_we, csr_tlbehi_we, csr_tlbelo0_we, csr_tlbelo1_we, csr_asid_we}), 32'd0);
    chk("reset_rand_index", 32'(rand_index), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // SRCH hit
    search_tlb_found = 1'b1; search_tlb_index = 5'd9; csr_tlbidx_in = 32'h8C00_0003;
    issue(OP_SRCH, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b1, 2,
          mk_done(1'b0, 5'b10000, 32'h0C00_0009, 32'h0, 32'h0, 32'h0, 10'h0));
    wait_drain();

    // SRCH miss
    search_tlb_found = 1'b0; search_tlb_index = 5'd17; csr_tlbidx_in = 32'h0C00_0003;
    issue(OP_SRCH, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b1, 2,
          mk_done(1'b0, 5'b10000, 32'h8C00_0003, 32'h0, 32'h0, 32'h0, 10'h0));
    wait_drain();

    // RD valid: PS from the entry, NE cleared, bit 30 and low 24 bits from the CSR
    tlbrd_valid = 1'b1; csr_tlbidx_in = 32'h3F12_34AB; tlbidx_out = 32'hD5FF_FFFF;
    tlbehi_out = 32'h1234_0000; tlbelo0_out = 32'h0000_1111; tlbelo1_out = 32'h0000_2222;
    asid_out = 10'h2A;
    issue(OP_RD, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b1, 2,
          mk_done(1'b0, 5'b11111, 32'h1512_34AB, 32'h1234_0000, 32'h0000_1111,
                  32'h0000_2222, 10'h2A));
    wait_drain();

    // RD invalid
    tlbrd_valid = 1'b0;
    issue(OP_RD, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b1, 2,
          mk_done(1'b0, 5'b11111, 32'h8012_34AB, 32'h0, 32'h0, 32'h0, 10'h0));
    wait_drain();

    // FILL accepted at counter 31, then again after the wrap
    issue(OP_FILL, 5'd0, 10'd0, 19'd0, 31, 1'b1, 1'b1, 1,
          mk_done(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    @(negedge clk);
    @(negedge clk);
    chk("fill_rand_hold", 32'(rand_index), 32'd31);
    issue(OP_FILL, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b1, 1,
          mk_done(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    wait_drain();

    // WR
    issue(OP_WR, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b1, 1,
          mk_done(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    wait_drain();

    // INVTLB legal and illegal op
    issue(OP_INV, 5'd3, 10'h155, 19'h4_5678, -1, 1'b1, 1'b1, 1,
          mk_done(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    wait_drain();
    issue(OP_INV, 5'd7, 10'h0AA, 19'h1_2345, -1, 1'b0, 1'b1, 1,
          mk_done(1'b1, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    wait_drain();

    // Flush in ISSUE: no enable, no done, ready again next cycle
    issue(OP_WR, 5'd0, 10'd0, 19'd0, -1, 1'b0, 1'b0, 0,
          mk_done(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_issue_ready", 32'(req_ready), 32'd1);
    wait_drain();

    // Flush in WAIT: completion still pulses, CSR writes dropped
    search_tlb_found = 1'b1; search_tlb_index = 5'd4;
    issue(OP_SRCH, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b1, 2,
          mk_done(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_drain();

    // No ret: timeout completion with exception
    resp_mute = 1'b1;
    issue(OP_SRCH, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b1, 5,
          mk_done(1'b1, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    wait_drain();

    // Reset asserted while waiting for ret
    issue(OP_RD, 5'd0, 10'd0, 19'd0, -1, 1'b1, 1'b0, 0,
          mk_done(1'b0, 5'b00000, 32'h0, 32'h0, 32'h0, 32'h0, 10'h0));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(req_ready), 32'd0);
    chk("rst_wait_done", {30'd0, done_valid, done_excp}, 32'd0);
    chk("rst_wait_enables", 32'({tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en}), 32'd0);
    chk("rst_wait_rand_index", 32'(rand_index), 32'd0);
    chk("rst_wait_tlbidx_wdata", csr_tlbidx_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_mute = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_mid_reset", 32'(req_ready), 32'd1);

    repeat (4) @(negedge clk);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    chk("enable_queue_empty", 32'(en_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_inst_ctrl.md
Name: tlb_inst_ctrl

Overview:
- EX-stage sequencer for the LoongArch TLB management instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Accepts one request from the EX pipeline and drives the enables and operands of the `ex2tlb` bundle on the address-translation unit.
- Captures the registered search/read results and produces a one-cycle CSR write-back bundle plus a done/exception pulse.
- Owns the TLBFILL random index generator.

Parameters:
- TLBNUM, 32, number of TLB entries.
- IDXW, $clog2(TLBNUM) (=5), index width.
- RET_TIMEOUT, 4, cycles to wait for `*_ret` before an error completion.

Ports:
- clk in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- req_valid in 1: request from EX.
- req_ready out 1: high only in IDLE.
- req_op in 3: operation code, from the package `tlb_op_t`.
- req_inv_op in 5: INVTLB op field.
- req_inv_asid in 10: INVTLB asid operand.
- req_inv_vpn in 19: INVTLB va[31:13].
- flush in 1: pipeline flush.
- csr_tlbidx_in in 32: current TLBIDX value.
- tlbsrch_en, tlbrd_en, tlbwr_en, tlbfill_en, invtlb_en out 1 each: TLB command enables.
- invtlb_op out 5, invtlb_asid out 10, invtlb_vpn out 19: INVTLB operands to the TLB.
- rand_index out IDXW: TLBFILL target index.
- tlbsrch_ret, tlbrd_ret in 1: registered completion strobes from the TLB.
- search_tlb_found in 1, search_tlb_index in IDXW: TLBSRCH result.
- tlbrd_valid in 1: TLBRD entry valid.
- tlbehi_out, tlbelo0_out, tlbelo1_out, tlbidx_out in 32 each; asid_out in 10: TLBRD data.
- csr_tlbidx_we, csr_tlbehi_we, csr_tlbelo0_we, csr_tlbelo1_we, csr_asid_we out 1 each: CSR write enables.
- csr_tlbidx_wdata, csr_tlbehi_wdata, csr_tlbelo0_wdata, csr_tlbelo1_wdata out 32 each; csr_asid_wdata out 10: CSR write data.
- done_valid out 1: one-cycle completion pulse.
- done_excp out 1: illegal INVTLB op or timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; rand counter 0; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid && !flush, latch op and operands; rand_index is latched from the free-running counter; go to ISSUE.
- ISSUE: exactly one enable for the latched op is high for one cycle.
  - INVTLB with inv_op>6: no enable; set excp; go to DONE.
  - Flush in ISSUE: suppress the enable and return to IDLE with no done pulse.
  - SRCH/RD go to WAIT. WR/FILL/INV go to DONE, since the TLB commits at that clock edge.
- WAIT (SRCH/RD only): when the matching `*_ret`=1, capture the result registers and go to DONE.
  - The counter increments per cycle. On reaching RET_TIMEOUT, set excp, make no CSR writes, go to DONE.
  - Flush in WAIT sets a drop flag.
- DONE: done_valid=1 for one cycle, then IDLE. CSR we's assert in this cycle only, and only if !drop && !flush && !excp.
- SRCH write-back:
  - Found: tlbidx_wdata = {1'b0, csr_tlbidx_in[30:IDXW], index}.
  - Miss: tlbidx_wdata = {1'b1, csr_tlbidx_in[30:0]}.
  - Only csr_tlbidx_we is asserted.
- RD write-back, valid:
  - tlbidx_wdata = {1'b0, csr_tlbidx_in[30], tlbidx_out[29:24], csr_tlbidx_in[23:0]}.
  - ehi/elo0/elo1/asid take the `*_out` values.
- RD write-back, invalid:
  - tlbidx_wdata = {1'b1, csr_tlbidx_in[30], 6'b0, csr_tlbidx_in[23:0]}.
  - ehi/elo0/elo1/asid are written 0.
- Rand counter: IDXW-bit free-running counter, +1 every cycle, wraps TLBNUM-1 -> 0. Its value is latched into rand_index at accept and held until the next accept.
- Latency from accept cycle T:
  - SRCH/RD: enable at T+1, ret at T+2, done at T+3.
  - WR/FILL/INV: enable at T+1, done at T+2.
- Reset mid-operation: return to IDLE immediately with outputs 0. Any enable already issued is not replayed.
- Back-to-back requests: the next accept is possible in the cycle after DONE.

Decomposition:
- Package `tlb_ctrl_pkg`:
  - `tlb_op_t` enum: SRCH=0, RD=1, WR=2, FILL=3, INV=4.
  - `tlb_ctrl_state_t`.
  - TLBIDX field constants: NE=31, PS=29:24, INDEX=4:0.
  - INVTLB_OP_MAX=6.
- One sub-module, `tlb_rand_idx`: the free-running counter with latch-on-accept.

Test Plan:
- SRCH hit: search_tlb_found=1, index=5'd9, csr_tlbidx_in=32'h8C00_0003 -> done at T+3, tlbidx_wdata=32'h0C00_0009, only tlbidx_we asserted.
- SRCH miss: found=0, csr_tlbidx_in=32'h0C00_0003 -> tlbidx_wdata=32'h8C00_0003.
- RD valid: tlbidx_out PS=6'd21, ehi=32'h1234_0000, asid_out=10'h2A -> tlbidx_wdata[29:24]=21, NE=0, ehi/asid written with those values.
- RD invalid: tlbrd_valid=0 -> NE=1, PS=0, ehi/elo0/elo1=0, asid=0.
- FILL across wrap: accept when counter=31 -> rand_index=31 held; tlbfill_en for one cycle at T+1; done at T+2; next accept uses the wrapped counter value.
- INVTLB op=7 -> no invtlb_en, done_excp=1, no CSR writes.
- flush in ISSUE -> no enable, no done, back in IDLE the next cycle.
- rst_n low during WAIT -> all outputs 0 asynchronously, req_ready=1 after release.
